usb_cmd_parser: RTL and testbench
=================================

# usb_cmd_parser

Byte-stream command frame parser that sits directly downstream of the USB CDC block. It consumes the received-byte stream (`uart_rx_data_out` / `uart_rx_data_valid_out`) in the PHY_CLKOUT domain and delineates frames. For each frame it extracts the command code and length, streams the payload to downstream function blocks, verifies the checksum, and reports success or a coded error.

## Interface
- `MAX_LEN`, default 256: maximum accepted payload length in bytes.
- `TIMEOUT_CYCLES`, default 600000: inter-byte timeout inside a frame (10 ms at 60 MHz).
- `PHY_CLKOUT` in 1: clock, 60 MHz.
- `RESET` in 1: reset, asynchronous, active-high.
- `in_data` in 8: received byte.
- `in_valid` in 1: one-cycle strobe per byte; back-to-back strobes are legal.
- `cmd_start` out 1: pulse when the header and length have been accepted.
- `cmd_type` out 8: command code, held from `cmd_start` until the next frame.
- `cmd_length` out 16: payload length, held with `cmd_type`.
- `payload_data` out 8: payload byte.
- `payload_valid` out 1: one-cycle strobe per payload byte.
- `payload_index` out 16: 0-based index of the current payload byte.
- `frame_ok` out 1: pulse when the checksum matches.
- `frame_err` out 1: pulse when the frame is aborted.
- `err_code` out 2: 1 = checksum, 2 = length exceeds `MAX_LEN`, 3 = timeout. Held until the next `frame_err`.

## Operation
- Frame format: `0xAA 0x55 CMD LEN_H LEN_L PAYLOAD[LEN] CHK`.
- `CHK` = (CMD + LEN_H + LEN_L + Σ PAYLOAD) mod 256, using an 8-bit wrapping accumulator.
- State transitions happen only on `in_valid`, except for timeout.
  - IDLE: `0xAA` → HDR2; any other byte is ignored.
  - HDR2: `0x55` → CMD; `0xAA` stays in HDR2 (resync); any other byte → IDLE.
  - CMD: latch the byte into the internal command register, start the accumulator with it → LEN_H.
  - LEN_H: latch the high length byte, accumulate → LEN_L.
  - LEN_L: form the length = {LEN_H, byte}.
    - Length > `MAX_LEN`: pulse `frame_err` with code 2 → IDLE.
    - Otherwise: accumulate, drive `cmd_start`, update `cmd_type`/`cmd_length`.
    - Next state is CHKSUM if the length is 0, else PAYLOAD.
  - PAYLOAD: for each byte, accumulate and emit `payload_valid`/`payload_data`/`payload_index`, then increment the index. After byte LEN-1 → CHKSUM.
  - CHKSUM: byte equals the accumulator → `frame_ok`; otherwise `frame_err` with code 1. Either way → IDLE.
- Timeout counter:
  - Cleared in IDLE and on every `in_valid`; increments otherwise.
  - Reaching `TIMEOUT_CYCLES-1` in any non-IDLE state → `frame_err` with code 3, → IDLE.
  - If a byte arrives in the same cycle as expiry, the byte wins and the counter clears.
- The payload is streamed before it is verified. Downstream blocks must discard the frame's effects on `frame_err`.
- No back-pressure: the parser accepts a byte every cycle.
- `cmd_start`, `frame_ok` and `frame_err` are mutually exclusive in any cycle.

## Timing
- All outputs are registered. Every response appears in the cycle after the `in_valid` that caused it (latency 1).
- For a timeout, `frame_err` appears in the cycle after the counter reaches `TIMEOUT_CYCLES-1`.
- Reset values: all pulses 0; `cmd_type`, `cmd_length`, `payload_data`, `payload_index` are 0; `err_code` is 0; state IDLE; accumulator and counters 0.
- Reset asserted mid-frame aborts immediately and asynchronously. No `frame_err` is issued for the aborted frame.
- A byte arriving in the cycle after a `frame_ok`/`frame_err` is parsed from IDLE (zero dead cycles).
- `payload_index` increments mod 2^16. It never wraps in practice because `MAX_LEN` ≤ 65535.
- `cmd_length` must be 16-bit; comparison against `MAX_LEN` is unsigned.

## Test plan
- Good frame: `AA 55 10 00 03 01 02 03 19`, back-to-back.
  - `cmd_start` with `cmd_type`=0x10, `cmd_length`=3.
  - Payload 01/02/03 at indices 0/1/2.
  - `frame_ok` exactly one cycle after the 0x19.
- Bad checksum: same frame ending in `0x18` → 3 payload strobes, then `frame_err` with `err_code`=1 and no `frame_ok`.
- Zero length: `AA 55 20 00 00 20` → `cmd_start` (`cmd_length`=0), no `payload_valid`, then `frame_ok`.
- Oversize: `AA 55 01 01 01` with `MAX_LEN`=256 → `frame_err` with `err_code`=2 after the LEN_L byte. A following good frame is then accepted.
- Resync and timeout:
  - Input `AA AA 55 30 00 00 30` → `frame_ok`.
  - Separately: send `AA 55 30`, then idle for `TIMEOUT_CYCLES` → a single `frame_err` with `err_code`=3.
- Reset mid-payload: assert `RESET` after 1 of 3 payload bytes → all outputs return to 0 with no pulses. A subsequent good frame parses correctly.

Source files
------------

// File: rtl/usb_cmd_parser.sv
// Command frame parser for the USB CDC receive byte stream.
// Frame: AA 55 CMD LEN_H LEN_L PAYLOAD[LEN] CHK, with CHK = 8-bit sum of CMD..PAYLOAD.
module usb_cmd_parser #(
  parameter int unsigned MAX_LEN        = 256,
  parameter int unsigned TIMEOUT_CYCLES = 600000
) (
  input  logic        PHY_CLKOUT,
  input  logic        RESET,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        cmd_start,
  output logic [7:0]  cmd_type,
  output logic [15:0] cmd_length,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic [15:0] payload_index,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_LENGTH   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, HDR2, CMD, LEN_H, LEN_L, PAYLOAD, CHKSUM
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      cmd_reg, cmd_next;
  logic [7:0]      len_h_reg, len_h_next;
  logic [7:0]      acc_reg, acc_next;
  logic [15:0]     idx_reg, idx_next;
  logic [TW-1:0]   timer_reg, timer_next;

  logic            cmd_start_next, payload_valid_next, frame_ok_next, frame_err_next;
  logic [7:0]      cmd_type_next, payload_data_next;
  logic [15:0]     cmd_length_next, payload_index_next;
  logic [1:0]      err_code_next;
  logic [15:0]     rx_len;

  assign rx_len = {len_h_reg, in_data};

  always_ff @(posedge PHY_CLKOUT or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      cmd_reg       <= '0;
      len_h_reg     <= '0;
      acc_reg       <= '0;
      idx_reg       <= '0;
      timer_reg     <= '0;
      cmd_start     <= 1'b0;
      cmd_type      <= '0;
      cmd_length    <= '0;
      payload_data  <= '0;
      payload_valid <= 1'b0;
      payload_index <= '0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= '0;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      len_h_reg     <= len_h_next;
      acc_reg       <= acc_next;
      idx_reg       <= idx_next;
      timer_reg     <= timer_next;
      cmd_start     <= cmd_start_next;
      cmd_type      <= cmd_type_next;
      cmd_length    <= cmd_length_next;
      payload_data  <= payload_data_next;
      payload_valid <= payload_valid_next;
      payload_index <= payload_index_next;
      frame_ok      <= frame_ok_next;
      frame_err     <= frame_err_next;
      err_code      <= err_code_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    cmd_next           = cmd_reg;
    len_h_next         = len_h_reg;
    acc_next           = acc_reg;
    idx_next           = idx_reg;
    cmd_start_next     = 1'b0;
    cmd_type_next      = cmd_type;
    cmd_length_next    = cmd_length;
    payload_data_next  = payload_data;
    payload_valid_next = 1'b0;
    payload_index_next = payload_index;
    frame_ok_next      = 1'b0;
    frame_err_next     = 1'b0;
    err_code_next      = err_code;

    // Timer only runs while a frame is open and the line is quiet.
    if (state_reg == IDLE || in_valid) begin
      timer_next = '0;
    end else begin
      timer_next = timer_reg + 1'b1;
    end

    if (in_valid) begin
      case (state_reg)
        IDLE: begin
          if (in_data == 8'hAA) state_next = HDR2;
        end
        HDR2: begin
          if (in_data == 8'h55)      state_next = CMD;
          else if (in_data != 8'hAA) state_next = IDLE;
        end
        CMD: begin
          cmd_next   = in_data;
          acc_next   = in_data;
          state_next = LEN_H;
        end
        LEN_H: begin
          len_h_next = in_data;
          acc_next   = acc_reg + in_data;
          state_next = LEN_L;
        end
        LEN_L: begin
          if ({16'd0, rx_len} > MAX_LEN) begin
            frame_err_next = 1'b1;
            err_code_next  = ERR_LENGTH;
            state_next     = IDLE;
          end else begin
            acc_next        = acc_reg + in_data;
            cmd_start_next  = 1'b1;
            cmd_type_next   = cmd_reg;
            cmd_length_next = rx_len;
            idx_next        = '0;
            state_next      = (rx_len == 16'd0) ? CHKSUM : PAYLOAD;
          end
        end
        PAYLOAD: begin
          acc_next           = acc_reg + in_data;
          payload_valid_next = 1'b1;
          payload_data_next  = in_data;
          payload_index_next = idx_reg;
          idx_next           = idx_reg + 16'd1;
          if (idx_reg == cmd_length - 16'd1) state_next = CHKSUM;
        end
        CHKSUM: begin
          if (in_data == acc_reg) begin
            frame_ok_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
            err_code_next  = ERR_CHECKSUM;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && timer_reg == TIMER_LAST) begin
      frame_err_next = 1'b1;
      err_code_next  = ERR_TIMEOUT;
      state_next     = IDLE;
    end
  end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Directed bench for usb_cmd_parser: each byte is checked for its registered response one cycle later.
module tb_usb_cmd_parser;

  localparam int unsigned MAX_LEN = 256;
  localparam int unsigned TMO     = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        cmd_start, payload_valid, frame_ok, frame_err;
  logic [7:0]  cmd_type, payload_data;
  logic [15:0] cmd_length, payload_index;
  logic [1:0]  err_code;

  int total  = 0;
  int passed = 0;

  usb_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .PHY_CLKOUT   (clk),
    .RESET        (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .cmd_start    (cmd_start),
    .cmd_type     (cmd_type),
    .cmd_length   (cmd_length),
    .payload_data (payload_data),
    .payload_valid(payload_valid),
    .payload_index(payload_index),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  // Present one byte on the next cycle; return 1 ns after the edge that consumes it.
  task automatic feed(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_start, payload_valid, frame_ok, frame_err} !== 4'b0000)
      $display("FAIL reset_pulses got %b want 0000", {cmd_start, payload_valid, frame_ok, frame_err});
    else passed++;
    total++;
    if ({cmd_type, cmd_length, payload_data, payload_index, err_code} !== 50'd0)
      $display("FAIL reset_values got %h want 0", {cmd_type, cmd_length, payload_data, payload_index, err_code});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({cmd_start, payload_valid, frame_ok, frame_err} !== 4'b0000)
      $display("FAIL post_reset_pulses got %b want 0000", {cmd_start, payload_valid, frame_ok, frame_err});
    else passed++;
  endtask

  // Pulse code per byte: {cmd_start, payload_valid, frame_ok, frame_err}.
  task automatic test_good_frame(input string tag);
    logic [7:0] f [0:8];
    logic [3:0] p [0:8];
    int pidx;
    f = '{8'hAA, 8'h55, 8'h10, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    p = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'h4, 4'h4, 4'h2};
    pidx = 0;
    for (int i = 0; i < 9; i++) begin
      feed(f[i]);
      total++;
      if ({cmd_start, payload_valid, frame_ok, frame_err} !== p[i])
        $display("FAIL %s_pulses byte %0d got %b want %b", tag, i, {cmd_start, payload_valid, frame_ok, frame_err}, p[i]);
      else passed++;
      if (p[i][3]) begin
        total++;
        if (cmd_type !== 8'h10 || cmd_length !== 16'd3)
          $display("FAIL %s_header got type %h len %0d want 10/3", tag, cmd_type, cmd_length);
        else passed++;
      end
      if (p[i][2]) begin
        total++;
        if (payload_data !== f[i] || payload_index !== 16'(pidx))
          $display("FAIL %s_payload got %h@%0d want %h@%0d", tag, payload_data, payload_index, f[i], pidx);
        else passed++;
        pidx++;
      end
    end
    quiet(1);
    @(posedge clk); #1;
    total++;
    if ({cmd_start, payload_valid, frame_ok, frame_err} !== 4'b0000)
      $display("FAIL %s_after got %b want 0000", tag, {cmd_start, payload_valid, frame_ok, frame_err});
    else passed++;
    $display("%s frame: cmd 10 len 3 done", tag);
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f [0:8];
    logic [3:0] p [0:8];
    f = '{8'hAA, 8'h55, 8'h10, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18};
    p = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'h4, 4'h4, 4'h1};
    for (int i = 0; i < 9; i++) begin
      feed(f[i]);
      total++;
      if ({cmd_start, payload_valid, frame_ok, frame_err} !== p[i])
        $display("FAIL badchk_pulses byte %0d got %b want %b", i, {cmd_start, payload_valid, frame_ok, frame_err}, p[i]);
      else passed++;
    end
    total++;
    if (err_code !== 2'd1) $display("FAIL badchk_code got %0d want 1", err_code);
    else passed++;
    quiet(1);
    $display("bad checksum frame: err_code %0d", err_code);
  endtask

  task automatic test_zero_len();
    logic [7:0] f [0:5];
    logic [3:0] p [0:5];
    f = '{8'hAA, 8'h55, 8'h20, 8'h00, 8'h00, 8'h20};
    p = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h2};
    for (int i = 0; i < 6; i++) begin
      feed(f[i]);
      total++;
      if ({cmd_start, payload_valid, frame_ok, frame_err} !== p[i])
        $display("FAIL zero_pulses byte %0d got %b want %b", i, {cmd_start, payload_valid, frame_ok, frame_err}, p[i]);
      else passed++;
      if (p[i][3]) begin
        total++;
        if (cmd_type !== 8'h20 || cmd_length !== 16'd0)
          $display("FAIL zero_header got type %h len %0d want 20/0", cmd_type, cmd_length);
        else passed++;
      end
    end
    quiet(1);
    $display("zero-length frame: cmd 20 done");
  endtask

  task automatic test_oversize();
    logic [7:0] f [0:4];
    logic [3:0] p [0:4];
    f = '{8'hAA, 8'h55, 8'h01, 8'h01, 8'h01};
    p = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    for (int i = 0; i < 5; i++) begin
      feed(f[i]);
      total++;
      if ({cmd_start, payload_valid, frame_ok, frame_err} !== p[i])
        $display("FAIL oversize_pulses byte %0d got %b want %b", i, {cmd_start, payload_valid, frame_ok, frame_err}, p[i]);
      else passed++;
    end
    total++;
    if (err_code !== 2'd2 || cmd_type !== 8'h20)
      $display("FAIL oversize_code got code %0d type %h want 2/20", err_code, cmd_type);
    else passed++;
    quiet(1);
    $display("oversize frame len 257: err_code %0d", err_code);
  endtask

  task automatic test_resync();
    logic [7:0] f [0:6];
    logic [3:0] p [0:6];
    f = '{8'hAA, 8'hAA, 8'h55, 8'h30, 8'h00, 8'h00, 8'h30};
    p = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h2};
    for (int i = 0; i < 7; i++) begin
      feed(f[i]);
      total++;
      if ({cmd_start, payload_valid, frame_ok, frame_err} !== p[i])
        $display("FAIL resync_pulses byte %0d got %b want %b", i, {cmd_start, payload_valid, frame_ok, frame_err}, p[i]);
      else passed++;
    end
    quiet(1);
    $display("resync frame AA AA 55: done");
  endtask

  task automatic test_timeout();
    int errs  = 0;
    int first = -1;
    feed(8'hAA); feed(8'h55); feed(8'h30);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 3 * TMO; k++) begin
      if (k > 1) @(negedge clk);
      @(posedge clk); #1;
      if (frame_err) begin
        errs++;
        if (first < 0) first = k;
        total++;
        if (err_code !== 2'd3) $display("FAIL timeout_code got %0d want 3", err_code);
        else passed++;
      end
      if (cmd_start || frame_ok || payload_valid) begin
        total++;
        $display("FAIL timeout_spurious cycle %0d got %b want 000", k, {cmd_start, frame_ok, payload_valid});
      end
    end
    total++;
    if (errs != 1 || first != int'(TMO))
      $display("FAIL timeout_count got %0d errs first at %0d want 1 at %0d", errs, first, TMO);
    else passed++;
    $display("timeout: %0d err pulse(s), first at cycle %0d", errs, first);
  endtask

  task automatic test_reset_mid();
    feed(8'hAA); feed(8'h55); feed(8'h10); feed(8'h00); feed(8'h03); feed(8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({cmd_start, payload_valid, frame_ok, frame_err, cmd_type, cmd_length, payload_data, payload_index, err_code} !== 54'd0)
      $display("FAIL midreset_async got %h want 0",
               {cmd_start, payload_valid, frame_ok, frame_err, cmd_type, cmd_length, payload_data, payload_index, err_code});
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cmd_start, payload_valid, frame_ok, frame_err} !== 4'b0000)
      $display("FAIL midreset_pulses got %b want 0000", {cmd_start, payload_valid, frame_ok, frame_err});
    else passed++;
    $display("reset mid-payload: outputs cleared");
  endtask

  task automatic test_back_to_back();
    logic [7:0] f [0:14];
    logic [3:0] p [0:14];
    f = '{8'hAA, 8'h55, 8'h20, 8'h00, 8'h00, 8'h20,
          8'hAA, 8'h55, 8'h10, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    p = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h2,
          4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'h4, 4'h4, 4'h2};
    for (int i = 0; i < 15; i++) begin
      feed(f[i]);
      total++;
      if ({cmd_start, payload_valid, frame_ok, frame_err} !== p[i])
        $display("FAIL b2b_pulses byte %0d got %b want %b", i, {cmd_start, payload_valid, frame_ok, frame_err}, p[i]);
      else passed++;
      if (p[i][2]) begin
        total++;
        if (payload_data !== f[i] || payload_index !== 16'(i - 11))
          $display("FAIL b2b_payload got %h@%0d want %h@%0d", payload_data, payload_index, f[i], i - 11);
        else passed++;
      end
    end
    quiet(1);
    $display("back-to-back frames: done");
  endtask

  initial begin
    test_reset();
    test_good_frame("good");
    test_bad_checksum();
    test_zero_len();
    test_oversize();
    test_good_frame("after_oversize");
    test_resync();
    test_timeout();
    test_reset_mid();
    test_good_frame("after_reset");
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
